// File: rtl/usb_rx_bit_recovery.sv
// usb_rx_bit_recovery
//   USB line receiver front end. Synchronises D+/D-, recovers bit timing from
//   line edges, and performs NRZI decode, bit unstuffing and SE0/EOP detection.
//   It hands one decoded bit per shift_en strobe to the downstream packet decoder.
//
//   Optional build macro: RX_GLITCH_FILTER_EN inserts a 3-sample majority filter
//   on each synchronised line. This adds 2 cycles of latency. Without the macro,
//   the synchroniser outputs feed edge detect directly.
//
// Ports
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   d_plus_in   raw D+ line
//   d_minus_in  raw D- line
//   shift_en    one-cycle strobe, rx_bit valid this cycle
//   rx_bit      NRZI-decoded, unstuffed data bit
//   eop         one-cycle pulse on valid end of packet (SE0 then J)
//   rx_error    one-cycle pulse on stuff error, SE1 or bad EOP
//   rx_active   high from first K edge until packet end or error
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | line idle, timer held at 0, waiting for falling D+ edge
// S_ACTIVE  | receiving packet bits
// S_EOP_SE0 | SE0 seen, expecting at most 2 SE0 bit times then J
// S_WAIT    | after an error, waiting for SE0 followed by J
module usb_rx_bit_recovery #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus_in,
   input  logic d_minus_in,
   output logic shift_en,
   output logic rx_bit,
   output logic eop,
   output logic rx_error,
   output logic rx_active
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] SAMPLE_PT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACTIVE  = 2'd1,
      S_EOP_SE0 = 2'd2,
      S_WAIT    = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] dp_sync_q, dm_sync_q;
   logic                   dp_s, dm_s;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dp_sync_q <= '1;
         dm_sync_q <= '0;
      end else begin
         dp_sync_q <= {dp_sync_q[SYNC_STAGES-2:0], d_plus_in};
         dm_sync_q <= {dm_sync_q[SYNC_STAGES-2:0], d_minus_in};
      end
   end

`ifdef RX_GLITCH_FILTER_EN
   logic [2:0] dp_flt_q, dm_flt_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dp_flt_q <= 3'b111;
         dm_flt_q <= 3'b000;
      end else begin
         dp_flt_q <= {dp_flt_q[1:0], dp_sync_q[SYNC_STAGES-1]};
         dm_flt_q <= {dm_flt_q[1:0], dm_sync_q[SYNC_STAGES-1]};
      end
   end

   // 2-of-3 majority: a lone one-cycle glitch can never win the vote
   assign dp_s = (dp_flt_q[0] & dp_flt_q[1]) | (dp_flt_q[1] & dp_flt_q[2]) | (dp_flt_q[0] & dp_flt_q[2]);
   assign dm_s = (dm_flt_q[0] & dm_flt_q[1]) | (dm_flt_q[1] & dm_flt_q[2]) | (dm_flt_q[0] & dm_flt_q[2]);
`else
   assign dp_s = dp_sync_q[SYNC_STAGES-1];
   assign dm_s = dm_sync_q[SYNC_STAGES-1];
`endif

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    ones_q;
   logic [1:0]    se0_cnt_q;
   logic          dp_d1_q;
   logic          prev_dp_q;
   logic          seen_se0_q;

   logic edge_det, sample, bit_val;
   logic line_se0, line_se1, line_j;

   assign edge_det = dp_s ^ dp_d1_q;
   assign line_se0 = ~dp_s & ~dm_s;
   assign line_se1 = dp_s & dm_s;
   assign line_j   = dp_s & ~dm_s;
   assign bit_val  = (dp_s == prev_dp_q);
   // an edge on the sample cycle re-times the bit instead of sampling it
   assign sample   = (state_q != S_IDLE) && !edge_det && (cnt_q == SAMPLE_PT);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ones_q     <= '0;
         se0_cnt_q  <= '0;
         dp_d1_q    <= 1'b1;
         prev_dp_q  <= 1'b1;
         seen_se0_q <= 1'b0;
         shift_en   <= 1'b0;
         rx_bit     <= 1'b0;
         eop        <= 1'b0;
         rx_error   <= 1'b0;
         rx_active  <= 1'b0;
      end else begin
         shift_en <= 1'b0;
         eop      <= 1'b0;
         rx_error <= 1'b0;
         dp_d1_q  <= dp_s;

         if (state_q == S_IDLE || edge_det || cnt_q == LAST_CNT) cnt_q <= '0;
         else                                                     cnt_q <= cnt_q + 1'b1;

         if (sample && !line_se0) prev_dp_q <= dp_s;
         // remembers whether the previous sample was SE0, across any state
         if (sample) seen_se0_q <= line_se0;

         case (state_q)
            S_IDLE: begin
               if (edge_det && !dp_s) begin
                  state_q   <= S_ACTIVE;
                  rx_active <= 1'b1;
                  prev_dp_q <= 1'b1;
                  ones_q    <= '0;
               end
            end
            S_ACTIVE: begin
               if (sample) begin
                  if (line_se0) begin
                     state_q   <= S_EOP_SE0;
                     se0_cnt_q <= 2'd1;
                  end else if (line_se1 || (ones_q == 3'd6 && bit_val)) begin
                     rx_error  <= 1'b1;
                     rx_active <= 1'b0;
                     state_q   <= S_WAIT;
                  end else if (ones_q == 3'd6) begin
                     ones_q <= '0;
                  end else begin
                     shift_en <= 1'b1;
                     rx_bit   <= bit_val;
                     ones_q   <= bit_val ? ones_q + 3'd1 : 3'd0;
                  end
               end
            end
            S_EOP_SE0: begin
               if (sample) begin
                  if (line_se0 && se0_cnt_q != 2'd2) begin
                     se0_cnt_q <= se0_cnt_q + 2'd1;
                  end else if (line_j) begin
                     eop       <= 1'b1;
                     rx_active <= 1'b0;
                     state_q   <= S_IDLE;
                  end else begin
                     rx_error  <= 1'b1;
                     rx_active <= 1'b0;
                     state_q   <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (sample && line_j && seen_se0_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
